// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths, requester indices and helpers for the writeback arbiter
package wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam int REQ_ALU = 0;
  localparam int REQ_LD  = 1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
    return reg_mask_t'(1) << addr;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - per-register outstanding-write bits, set by claims and cleared by writebacks
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      claim_valid,
  input  reg_addr_t claim_addr,
  input  logic      clr_valid,
  input  reg_addr_t clr_addr,
  output reg_mask_t busy
);

  reg_mask_t busy_q;
  reg_mask_t busy_d;

  // Clear is applied first so a same-register claim in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid && (clr_addr != '0)) begin
      busy_d = busy_d & ~reg_onehot(clr_addr);
    end
    if (claim_valid && (claim_addr != '0)) begin
      busy_d = busy_d | reg_onehot(claim_addr);
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-requester round-robin writeback arbiter with registered regfile write port
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NREQ-1:0]                       req_valid,
  output logic [NREQ-1:0]                       req_ready,
  input  logic [NREQ-1:0][REG_ADDR_W-1:0]       req_addr,
  input  logic [NREQ-1:0][REG_DATA_W-1:0]       req_data,
  input  logic                                  claim_valid,
  input  logic [REG_ADDR_W-1:0]                 claim_addr,
  output logic                                  reg_wr,
  output logic [REG_ADDR_W-1:0]                 r2,
  output logic [REG_DATA_W-1:0]                 data2,
  output logic [NUM_REGS-1:0]                   busy
);

  logic      prio_q, prio_d;
  logic      reg_wr_q, reg_wr_d;
  reg_addr_t r2_q, r2_d;
  reg_data_t data2_q, data2_d;

  logic [NREQ-1:0] accept;
  logic            acc_any;
  reg_addr_t       win_addr;
  reg_data_t       win_data;

  // Pointer only moves after real contention, handing the next tie to the loser.
  always_comb begin
    req_ready = '0;
    prio_d    = prio_q;
    if (rst_n) begin
      if (req_valid[REQ_ALU] && req_valid[REQ_LD]) begin
        if (prio_q) begin
          req_ready[REQ_LD] = 1'b1;
        end else begin
          req_ready[REQ_ALU] = 1'b1;
        end
        prio_d = ~prio_q;
      end else begin
        req_ready = req_valid;
      end
    end
  end

  always_comb begin
    accept   = req_valid & req_ready;
    acc_any  = |accept;
    win_addr = accept[REQ_LD] ? req_addr[REQ_LD] : req_addr[REQ_ALU];
    win_data = accept[REQ_LD] ? req_data[REQ_LD] : req_data[REQ_ALU];
  end

  always_comb begin
    reg_wr_d = acc_any && (win_addr != '0);
    r2_d     = r2_q;
    data2_d  = data2_q;
    if (acc_any) begin
      r2_d    = win_addr;
      data2_d = win_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q   <= 1'b0;
      reg_wr_q <= 1'b0;
      r2_q     <= '0;
      data2_q  <= '0;
    end else begin
      prio_q   <= prio_d;
      reg_wr_q <= reg_wr_d;
      r2_q     <= r2_d;
      data2_q  <= data2_d;
    end
  end

  assign reg_wr = reg_wr_q;
  assign r2     = r2_q;
  assign data2  = data2_q;

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .clr_valid   (acc_any),
    .clr_addr    (win_addr),
    .busy        (busy)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic                            clk;
  logic                            rst_n;
  logic [1:0]                      req_valid;
  logic [1:0]                      req_ready;
  logic [1:0][REG_ADDR_W-1:0]      req_addr;
  logic [1:0][REG_DATA_W-1:0]      req_data;
  logic                            claim_valid;
  logic [REG_ADDR_W-1:0]           claim_addr;
  logic                            reg_wr;
  logic [REG_ADDR_W-1:0]           r2;
  logic [REG_DATA_W-1:0]           data2;
  logic [NUM_REGS-1:0]             busy;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.NREQ(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .reg_wr      (reg_wr),
    .r2          (r2),
    .data2       (data2),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 2'b11;
    req_addr[0] = 5'd0;
    req_addr[1] = 5'd0;
    req_data[0] = 32'h0;
    req_data[1] = 32'h0;
    claim_valid = 1'b1;
    claim_addr  = 5'd3;
    #1;
    chk("reset_ready", {30'd0, req_ready}, 32'h0);
    tick();
    tick();
    chk("reset_reg_wr", {31'd0, reg_wr}, 32'h0);
    chk("reset_r2", {27'd0, r2}, 32'h0);
    chk("reset_data2", data2, 32'h0);
    chk("reset_busy", busy, 32'h0);

    rst_n       = 1'b1;
    req_valid   = 2'b00;
    claim_valid = 1'b0;
    tick();

    // single ALU write
    req_valid   = 2'b01;
    req_addr[0] = 5'd5;
    req_data[0] = 32'hDEADBEEF;
    #1;
    chk("alu_ready", {30'd0, req_ready}, 32'h1);
    tick();
    chk("alu_reg_wr", {31'd0, reg_wr}, 32'h1);
    chk("alu_r2", {27'd0, r2}, 32'd5);
    chk("alu_data2", data2, 32'hDEADBEEF);
    req_valid = 2'b00;
    tick();
    chk("idle_reg_wr", {31'd0, reg_wr}, 32'h0);
    chk("idle_r2_hold", {27'd0, r2}, 32'd5);
    chk("idle_data2_hold", data2, 32'hDEADBEEF);

    // contention: ALU, load, ALU
    req_valid   = 2'b11;
    req_addr[0] = 5'd3;
    req_addr[1] = 5'd4;
    req_data[0] = 32'hA0A0A0A0;
    req_data[1] = 32'hB1B1B1B1;
    #1;
    chk("cont1_ready", {30'd0, req_ready}, 32'h1);
    tick();
    chk("cont1_r2", {27'd0, r2}, 32'd3);
    chk("cont1_data2", data2, 32'hA0A0A0A0);
    chk("cont2_ready", {30'd0, req_ready}, 32'h2);
    tick();
    chk("cont2_reg_wr", {31'd0, reg_wr}, 32'h1);
    chk("cont2_r2", {27'd0, r2}, 32'd4);
    chk("cont2_data2", data2, 32'hB1B1B1B1);
    chk("cont3_ready", {30'd0, req_ready}, 32'h1);
    tick();
    chk("cont3_r2", {27'd0, r2}, 32'd3);
    req_valid = 2'b00;

    // zero-address load write
    req_valid   = 2'b10;
    req_addr[1] = 5'd0;
    req_data[1] = 32'h1234;
    #1;
    chk("zero_ready", {30'd0, req_ready}, 32'h2);
    tick();
    chk("zero_reg_wr", {31'd0, reg_wr}, 32'h0);
    chk("zero_busy", busy, 32'h0);
    req_valid = 2'b00;

    // claim 7, hold a cycle, then ALU write to 7
    claim_valid = 1'b1;
    claim_addr  = 5'd7;
    tick();
    chk("claim7_busy", busy, 32'h0000_0080);
    claim_valid = 1'b0;
    tick();
    chk("claim7_hold", busy, 32'h0000_0080);
    req_valid   = 2'b01;
    req_addr[0] = 5'd7;
    req_data[0] = 32'h77;
    tick();
    chk("wr7_busy", busy, 32'h0);
    chk("wr7_r2", {27'd0, r2}, 32'd7);
    req_valid = 2'b00;

    claim_valid = 1'b1;
    claim_addr  = 5'd0;
    tick();
    chk("claim0_busy", busy, 32'h0);

    // claim and write same register in one cycle
    claim_addr = 5'd9;
    tick();
    chk("claim9_busy", busy, 32'h0000_0200);
    req_valid   = 2'b10;
    req_addr[1] = 5'd9;
    req_data[1] = 32'h99;
    #1;
    chk("coll_ready", {30'd0, req_ready}, 32'h2);
    tick();
    chk("coll_busy", busy, 32'h0000_0200);
    chk("coll_reg_wr", {31'd0, reg_wr}, 32'h1);
    chk("coll_r2", {27'd0, r2}, 32'd9);
    chk("coll_data2", data2, 32'h99);

    // claim 12 while writing 9: both take effect
    claim_addr = 5'd12;
    tick();
    chk("diff_busy", busy, 32'h0000_1000);
    req_valid = 2'b00;
    tick();
    chk("reclaim_busy", busy, 32'h0000_1000);
    claim_valid = 1'b0;

    // accept write to 6, then reset
    req_valid   = 2'b01;
    req_addr[0] = 5'd6;
    req_data[0] = 32'h66;
    tick();
    chk("pre_rst_reg_wr", {31'd0, reg_wr}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_ready", {30'd0, req_ready}, 32'h0);
    tick();
    chk("rst_reg_wr", {31'd0, reg_wr}, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_r2", {27'd0, r2}, 32'h0);
    rst_n       = 1'b1;
    req_valid   = 2'b11;
    req_addr[0] = 5'd3;
    req_addr[1] = 5'd4;
    #1;
    chk("post_rst_prio", {30'd0, req_ready}, 32'h1);
    tick();
    req_valid = 2'b00;
    chk("post_rst_r2", {27'd0, r2}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
